// File: rtl/join_level_sync.sv
// Two-input join: holds one word per channel, emits one joined beat when both slots are full.
// Latency: jval one cycle after the later accept. Backpressure: rdyk drops while slot k waits, and a slot that empties on a join can refill in the same cycle.
// Optional statistics counters are built only when JOIN_STATS_EN is defined.
module join_level_sync #(
    parameter int DW    = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dval1,
    input  logic [DW-1:0]    d1,
    output logic             rdy1,
    input  logic             dval2,
    input  logic [DW-1:0]    d2,
    output logic             rdy2,
    output logic             jval,
    output logic [DW-1:0]    jd1,
    output logic [DW-1:0]    jd2,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] join_cnt
`ifdef JOIN_STATS_EN
    ,
    output logic [CNT_W-1:0] rise1_cnt,
    output logic [CNT_W-1:0] rise2_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    logic          pend1, pend2;
    logic [DW-1:0] slot1, slot2;
    logic          acc1, acc2;

    assign jval = pend1 & pend2;
    assign rdy1 = !pend1 | jval;
    assign rdy2 = !pend2 | jval;
    assign acc1 = dval1 & rdy1;
    assign acc2 = dval2 & rdy2;
    assign jd1  = jval ? slot1 : '0;
    assign jd2  = jval ? slot2 : '0;

    // A slot being drained by a join stays pending if it is refilled on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
            slot1 <= '0;
            slot2 <= '0;
        end else begin
            if (acc1) begin
                pend1 <= 1'b1;
                slot1 <= d1;
            end else if (jval) begin
                pend1 <= 1'b0;
            end
            if (acc2) begin
                pend2 <= 1'b1;
                slot2 <= d2;
            end else if (jval) begin
                pend2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            join_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (jval)
                join_cnt <= join_cnt + 1'b1;
        end
    end

`ifdef JOIN_STATS_EN
    logic prev1, prev2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1     <= 1'b0;
            prev2     <= 1'b0;
            rise1_cnt <= '0;
            rise2_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            prev1 <= dval1;
            prev2 <= dval2;
            if (dval1 && !prev1)
                rise1_cnt <= rise1_cnt + 1'b1;
            if (dval2 && !prev2)
                rise2_cnt <= rise2_cnt + 1'b1;
            if (pend1 ^ pend2)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_join_level_sync.sv
// Bench for join_level_sync: directed scenarios then random traffic, checked against a queue model.
module tb_join_level_sync;

    localparam int DW    = 11;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             dval1, dval2;
    logic [DW-1:0]    d1, d2;
    logic             rdy1, rdy2, jval;
    logic [DW-1:0]    jd1, jd2;
    logic [CNT_W-1:0] cycle_cnt, join_cnt;
`ifdef JOIN_STATS_EN
    logic [CNT_W-1:0] rise1_cnt, rise2_cnt, wait_cnt;
`endif

    join_level_sync #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dval1     (dval1),
        .d1        (d1),
        .rdy1      (rdy1),
        .dval2     (dval2),
        .d2        (d2),
        .rdy2      (rdy2),
        .jval      (jval),
        .jd1       (jd1),
        .jd2       (jd2),
        .cycle_cnt (cycle_cnt),
        .join_cnt  (join_cnt)
`ifdef JOIN_STATS_EN
        ,
        .rise1_cnt (rise1_cnt),
        .rise2_cnt (rise2_cnt),
        .wait_cnt  (wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel holds at most one waiting word; a join pops one from each.
    logic [DW-1:0]    q1[$];
    logic [DW-1:0]    q2[$];
    logic [CNT_W-1:0] m_cycle, m_join, m_rise1, m_rise2, m_wait;
    logic             m_prev1, m_prev2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_jval();
        return (q1.size() > 0) && (q2.size() > 0);
    endfunction

    task automatic model_clear();
        q1.delete();
        q2.delete();
        m_cycle = '0;
        m_join  = '0;
        m_rise1 = '0;
        m_rise2 = '0;
        m_wait  = '0;
        m_prev1 = 1'b0;
        m_prev2 = 1'b0;
    endtask

    task automatic check_outputs();
        bit jv;
        jv = m_jval();
        chk("jval", {31'b0, jval}, {31'b0, jv});
        chk("jd1", 32'(jd1), jv ? 32'(q1[0]) : 32'd0);
        chk("jd2", 32'(jd2), jv ? 32'(q2[0]) : 32'd0);
        chk("rdy1", {31'b0, rdy1}, {31'b0, (q1.size() == 0) || jv});
        chk("rdy2", {31'b0, rdy2}, {31'b0, (q2.size() == 0) || jv});
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cycle));
        chk("join_cnt", 32'(join_cnt), 32'(m_join));
`ifdef JOIN_STATS_EN
        chk("rise1_cnt", 32'(rise1_cnt), 32'(m_rise1));
        chk("rise2_cnt", 32'(rise2_cnt), 32'(m_rise2));
        chk("wait_cnt", 32'(wait_cnt), 32'(m_wait));
`endif
    endtask

    // Called on the falling edge with inputs already driven; returns on the next falling edge.
    task automatic tick();
        bit jv, a1, a2, one_waiting;
        check_outputs();
        jv = m_jval();
        a1 = dval1 && ((q1.size() == 0) || jv);
        a2 = dval2 && ((q2.size() == 0) || jv);
        one_waiting = (q1.size() > 0) != (q2.size() > 0);
        @(posedge clk);
        if (jv) begin
            void'(q1.pop_front());
            void'(q2.pop_front());
            m_join++;
        end
        if (a1) q1.push_back(d1);
        if (a2) q2.push_back(d2);
        m_cycle++;
        if (dval1 && !m_prev1) m_rise1++;
        if (dval2 && !m_prev2) m_rise2++;
        if (one_waiting) m_wait++;
        m_prev1 = dval1;
        m_prev2 = dval2;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        model_clear();
        check_outputs();
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic drive(input logic v1, input logic [DW-1:0] x1, input logic v2, input logic [DW-1:0] x2);
        dval1 = v1;
        d1    = x1;
        dval2 = v2;
        d2    = x2;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        model_clear();

        // Reset held 5 clocks, then cycle counter after 10 idle clocks.
        do_reset(5);
        repeat (10) tick();
        chk("cycle_cnt_10", 32'(cycle_cnt), 32'd10);

        // Channel 1 waits three cycles for channel 2.
        drive(1'b1, 11'h123, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        repeat (3) begin
            chk("s1_rdy1_low", {31'b0, rdy1}, 32'd0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 11'h7FF);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("s1_jval", {31'b0, jval}, 32'd1);
        chk("s1_jd1", 32'(jd1), 32'h123);
        chk("s1_jd2", 32'(jd2), 32'h7FF);
        tick();
        chk("s1_jval_once", {31'b0, jval}, 32'd0);
        chk("s1_join_cnt", 32'(join_cnt), 32'd1);

        // Simultaneous accept.
        drive(1'b1, 11'd5, 1'b1, 11'd9);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("s2_jd1", 32'(jd1), 32'd5);
        chk("s2_jd2", 32'(jd2), 32'd9);
        tick();

        // Back-to-back stream, both valids held high.
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(i), 1'b1, DW'(i));
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        chk("s4_join_cnt", 32'(join_cnt), 32'd9);
        chk("s4_last_jd1", 32'(jd1), 32'd9);
        repeat (2) tick();

        // Reset discards a pending word.
        drive(1'b1, 11'h055, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        do_reset(1);
        drive(1'b1, 11'h0AA, 1'b1, 11'h0BB);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("s5_jd1", 32'(jd1), 32'h0AA);
        chk("s5_jd2", 32'(jd2), 32'h0BB);
        tick();
        chk("s5_join_cnt", 32'(join_cnt), 32'd1);

        // dval1 toggled four times while channel 2 stays idle.
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(i + 1), 1'b0, '0);
            tick();
            drive(1'b0, '0, 1'b0, '0);
            tick();
        end
`ifdef JOIN_STATS_EN
        chk("s6_rise1_cnt", 32'(rise1_cnt), 32'd4);
        chk("s6_wait_cnt", 32'(wait_cnt), 32'd7);
`endif
        chk("s6_rdy1", {31'b0, rdy1}, 32'd0);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, DW'($urandom),
                  ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, DW'($urandom));
            if ($urandom_range(0, 99) < 2)
                do_reset($urandom_range(1, 2));
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
